// File: rtl/seq_detector_param_if.sv
// Serial detector bus: sample controls and data in, match flag and count out.
interface seq_detector_param_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             x;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    // Stream source side
    modport master (
        output en,
        output clr,
        output x,
        input  y,
        input  match_cnt
    );

    // Detector side
    modport slave (
        input  en,
        input  clr,
        input  x,
        output y,
        output match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with selectable overlap and Mealy/Moore
// output timing, sample enable, synchronous clear and saturating match counter.
module seq_detector_param #(
    parameter int unsigned          PAT_W   = 4,
    parameter logic [PAT_W-1:0]     PATTERN = 4'b1001,
    parameter bit                   OVERLAP = 1'b1,
    parameter bit                   MOORE   = 1'b0,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_param_if.slave  bus
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [HIST_W-1:0] hist;
    logic [FILL_W-1:0] fill;
    logic              y_reg;
    logic [CNT_W-1:0]  match_cnt;

    logic [PAT_W-1:0]  window_c;
    logic              hit_c;
    logic [HIST_W-1:0] hist_next_c;
    logic [FILL_W-1:0] fill_next_c;
    logic [CNT_W-1:0]  cnt_next_c;

    // Match decode: the full window is the held history plus the bit on x now
    always_comb begin
        window_c = {hist, bus.x};
        hit_c    = bus.en & ~bus.clr & (fill == FILL_MAX) & (window_c == PATTERN);
    end

    // Next history/fill/count for an accepted bit; a non-overlap hit invalidates history
    always_comb begin
        hist_next_c = HIST_W'(window_c);
        fill_next_c = fill;
        cnt_next_c  = match_cnt;
        if (fill != FILL_MAX) begin
            fill_next_c = fill + FILL_W'(1);
        end
        if (hit_c && !OVERLAP) begin
            fill_next_c = '0;
        end
        if (hit_c && (match_cnt != '1)) begin
            cnt_next_c = match_cnt + CNT_W'(1);
        end
    end

    // History shift register and valid-bit count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.en) begin
            hist <= hist_next_c;
            fill <= fill_next_c;
        end
    end

    // Registered match flag, used as the output in Moore mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_reg <= 1'b0;
        end else begin
            y_reg <= hit_c;
        end
    end

    // Saturating match counter, bumped on the edge accepting the final bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (bus.clr) begin
            match_cnt <= '0;
        end else if (bus.en) begin
            match_cnt <= cnt_next_c;
        end
    end

    // Output timing select
    assign bus.y         = MOORE ? y_reg : hit_c;
    assign bus.match_cnt = match_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param across four parameter configurations.
module tb_seq_detector_param;

    logic clk;
    logic reset;
    logic en;
    logic clr;
    logic x;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detector_param_if #(.CNT_W(8)) bus_a ();
    seq_detector_param_if #(.CNT_W(8)) bus_b ();
    seq_detector_param_if #(.CNT_W(8)) bus_c ();
    seq_detector_param_if #(.CNT_W(2)) bus_d ();

    assign bus_a.en = en;  assign bus_a.clr = clr;  assign bus_a.x = x;
    assign bus_b.en = en;  assign bus_b.clr = clr;  assign bus_b.x = x;
    assign bus_c.en = en;  assign bus_c.clr = clr;  assign bus_c.x = x;
    assign bus_d.en = en;  assign bus_d.clr = clr;  assign bus_d.x = x;

    // Default: 1001, overlapping, Mealy
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    // Non-overlapping, Mealy
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    // Overlapping, Moore
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));
    // Two-bit all-ones pattern with a 2-bit saturating counter
    seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2))
        dut_d (.clk(clk), .reset(reset), .bus(bus_d.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, then let combinational outputs settle
    task automatic put(input logic e, input logic c, input logic b);
        @(negedge clk);
        en  = e;
        clr = c;
        x   = b;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        put(1'b0, 1'b1, 1'b0);
        edge_wait();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        x     = 1'b0;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (bus_a.y !== 1'b0 || bus_a.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_a: y=%b cnt=%0d, expected y=0 cnt=0", bus_a.y, bus_a.match_cnt);
        end
        n_checks++;
        if (bus_c.y !== 1'b0 || bus_c.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_c: y=%b cnt=%0d, expected y=0 cnt=0", bus_c.y, bus_c.match_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_overlap_mealy();
        bit xs [7] = '{1, 0, 0, 1, 0, 0, 1};
        bit ey [7] = '{0, 0, 0, 1, 0, 0, 1};
        int ec [7] = '{0, 0, 0, 1, 1, 1, 2};
        do_clr();
        for (int i = 0; i < 7; i++) begin
            put(1'b1, 1'b0, xs[i]);
            n_checks++;
            if (bus_a.y !== ey[i]) begin
                n_fail++;
                $display("FAIL ovl_y bit%0d: got %b expected %b", i + 1, bus_a.y, ey[i]);
            end
            edge_wait();
            n_checks++;
            if (bus_a.match_cnt !== 8'(ec[i])) begin
                n_fail++;
                $display("FAIL ovl_cnt bit%0d: got %0d expected %0d", i + 1, bus_a.match_cnt, ec[i]);
            end
        end
    endtask

    task automatic test_non_overlap();
        bit xs [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        bit ey [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int ec [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
        do_clr();
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 1'b0, xs[i]);
            n_checks++;
            if (bus_b.y !== ey[i]) begin
                n_fail++;
                $display("FAIL novl_y bit%0d: got %b expected %b", i + 1, bus_b.y, ey[i]);
            end
            edge_wait();
            n_checks++;
            if (bus_b.match_cnt !== 8'(ec[i])) begin
                n_fail++;
                $display("FAIL novl_cnt bit%0d: got %0d expected %0d", i + 1, bus_b.match_cnt, ec[i]);
            end
        end
    endtask

    task automatic test_moore();
        bit xs [7] = '{1, 0, 0, 1, 0, 0, 1};
        bit ey [7] = '{0, 0, 0, 1, 0, 0, 1};
        int ec [7] = '{0, 0, 0, 1, 1, 1, 2};
        do_clr();
        for (int i = 0; i < 7; i++) begin
            put(1'b1, 1'b0, xs[i]);
            n_checks++;
            if (i == 4 ? bus_c.y !== 1'b1 : (i != 0 && i != 7 && bus_c.y !== ey[i - 1 < 0 ? 0 : i - 1])) begin
                n_fail++;
                $display("FAIL moore_pre bit%0d: got %b", i + 1, bus_c.y);
            end
            edge_wait();
            n_checks++;
            if (bus_c.y !== ey[i] || bus_c.match_cnt !== 8'(ec[i])) begin
                n_fail++;
                $display("FAIL moore_post bit%0d: y=%b cnt=%0d expected y=%b cnt=%0d",
                         i + 1, bus_c.y, bus_c.match_cnt, ey[i], ec[i]);
            end
        end
        put(1'b0, 1'b0, 1'b0);
        edge_wait();
        n_checks++;
        if (bus_c.y !== 1'b0 || bus_c.match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL moore_idle: y=%b cnt=%0d expected y=0 cnt=2", bus_c.y, bus_c.match_cnt);
        end
    endtask

    task automatic test_enable_gaps();
        bit es [7] = '{1, 1, 0, 0, 0, 1, 1};
        bit xs [7] = '{1, 0, 1, 0, 1, 0, 1};
        bit ey [7] = '{0, 0, 0, 0, 0, 0, 1};
        do_clr();
        for (int i = 0; i < 7; i++) begin
            put(es[i], 1'b0, xs[i]);
            n_checks++;
            if (bus_a.y !== ey[i]) begin
                n_fail++;
                $display("FAIL gap_y step%0d: got %b expected %b", i + 1, bus_a.y, ey[i]);
            end
            edge_wait();
        end
        n_checks++;
        if (bus_a.match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_cnt: got %0d expected 1", bus_a.match_cnt);
        end
        // Final bit offered while en=0 must not match; partial progress survives
        do_clr();
        put(1'b1, 1'b0, 1'b1); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus_a.y !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_en0_y: got %b expected 0", bus_a.y);
        end
        edge_wait();
        n_checks++;
        if (bus_a.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL gap_en0_cnt: got %0d expected 0", bus_a.match_cnt);
        end
        put(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus_a.y !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_resume_y: got %b expected 1", bus_a.y);
        end
        edge_wait();
    endtask

    task automatic test_clear_and_reset();
        do_clr();
        put(1'b1, 1'b0, 1'b1); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (bus_a.y !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_y: got %b expected 0", bus_a.y);
        end
        edge_wait();
        put(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus_a.y !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_after_y: got %b expected 0", bus_a.y);
        end
        edge_wait();
        n_checks++;
        if (bus_a.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_cnt: got %0d expected 0", bus_a.match_cnt);
        end
        // Build up a count and a pending Mealy match, then reset mid-cycle
        do_clr();
        put(1'b1, 1'b0, 1'b1); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b1); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b0); edge_wait();
        put(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus_a.y !== 1'b1 || bus_a.match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_rst: y=%b cnt=%0d expected y=1 cnt=1", bus_a.y, bus_a.match_cnt);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus_a.y !== 1'b0 || bus_a.match_cnt !== 8'd0 || bus_c.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_rst: y_a=%b cnt_a=%0d cnt_c=%0d expected 0 0 0",
                     bus_a.y, bus_a.match_cnt, bus_c.match_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ey [6] = '{0, 1, 1, 1, 1, 1};
        int ec [6] = '{0, 1, 2, 3, 3, 3};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            put(1'b1, 1'b0, 1'b1);
            n_checks++;
            if (bus_d.y !== ey[i]) begin
                n_fail++;
                $display("FAIL b2b_y bit%0d: got %b expected %b", i + 1, bus_d.y, ey[i]);
            end
            edge_wait();
            n_checks++;
            if (bus_d.match_cnt !== 2'(ec[i])) begin
                n_fail++;
                $display("FAIL b2b_cnt bit%0d: got %0d expected %0d", i + 1, bus_d.match_cnt, ec[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_mealy();
        test_non_overlap();
        test_moore();
        test_enable_gaps();
        test_clear_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. Generalises the single fixed Mealy sequence detector to any pattern width and value. Overlap/non-overlap and Mealy/Moore output timing are both parameter-selectable, and the block adds an enable, a synchronous clear and a saturating match counter. It sits on a 1-bit serial input stream and flags each occurrence of the pattern to downstream control logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1001, target pattern, PAT_W bits; MSB is the oldest (first-received) bit.
OVERLAP, 1, 1 = overlapping matches counted; 0 = history restarts after each match.
MOORE, 0, 0 = Mealy (combinational y, same cycle as last bit); 1 = Moore (registered y, one cycle later).
CNT_W, 8, width of match counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  sample enable; x is consumed only on cycles with en=1
clr  input  1  synchronous clear of history, y register and counter
x  input  1  serial data bit
y  output  1  match indication
match_cnt  output  CNT_W  number of matches since reset/clr, saturating

Behaviour:
- Reset (reset=0, async): hist=0, fill=0, y_reg=0, match_cnt=0. Mealy y=0 because fill=0.
- Internal state:
  - hist: PAT_W-1 bits, the previous accepted bits, newest in LSB.
  - fill: 0..PAT_W-1, the count of valid bits held in hist.
- hit = en & ~clr & (fill==PAT_W-1) & ({hist,x}==PATTERN).
- Posedge, clr=1 (priority over en): hist=0, fill=0, y_reg=0, match_cnt=0.
- Posedge, clr=0, en=1:
  - hist <= {hist[PAT_W-3:0],x}. When PAT_W=2, hist <= x.
  - fill <= min(fill+1, PAT_W-1).
  - If hit and OVERLAP=0: fill <= 0. Hist is still shifted but is treated as invalid.
  - If hit: match_cnt <= match_cnt+1, holding at 2^CNT_W-1 (no wrap).
- Posedge, clr=0, en=0: hist, fill and match_cnt hold.
- y_reg:
  - In all non-reset cycles, y_reg <= hit. Because hit requires en=1 and clr=0, y_reg clears on any cycle with en=0 or clr=1.
- Output y:
  - MOORE=0: y = hit (combinational from x). It is high in the cycle the final pattern bit is presented, and it is low while en=0 or clr=1.
  - MOORE=1: y = y_reg. It is high for exactly one cycle, the cycle after the final bit's accepting edge.
- match_cnt is registered and updates on the same edge that accepts the final bit.
- Matching starts only after PAT_W bits have been accepted since reset, clr or a non-overlap match. Bits present in hist before that never cause a hit.
- Gaps in en do not break a partial match: only accepted bits form the sequence.
- Reset asserted mid-sequence discards all partial progress immediately.
- Matches adjacent in consecutive cycles are legal (e.g. PATTERN all ones, OVERLAP=1): y stays high across those cycles.

Test Plan:
1. Defaults (1001, OVERLAP=1, Mealy), en=1, x=1,0,0,1,0,0,1 -> y=1 on bits 4 and 7 only; match_cnt=2 after bit 7.
2. Same stream with OVERLAP=0 -> y=1 on bit 4 only, match_cnt=1. Then continue x=0,0,1 (stream bits 5-10 = 0,0,1,0,0,1) -> next y=1 on bit 10, since the earliest window after the restart is bits 7-10; match_cnt=2.
3. MOORE=1, stream of test 1 -> y high in the cycle after bits 4 and 7 are accepted (one-cycle pulses); match_cnt timing unchanged.
4. Stream 1,0,(en=0 for 3 cycles with x toggling),0,1 -> single match on the final bit. Separately, en=0 on the cycle x=1 is presented as the 4th bit -> no y.
5. Assert clr after bits 1,0,0, then feed 1 -> no match and match_cnt=0. Separately, pulse reset low mid-sequence -> y and match_cnt are 0 immediately, before the next clock edge.
6. CNT_W=2, PATTERN=2'b11, PAT_W=2, OVERLAP=1, x=1 for 6 cycles -> y=1 from bit 2 onward continuously; match_cnt = 1,2,3,3,3.
